// File: rtl/inference_sequencer_pkg.sv
// Shared types and sizing for the 14x14 binary-image classifier sequencer.
package nnacc_pkg;
  localparam int ROW_W       = 7;
  localparam int NUM_ROWS    = 28;
  localparam int NUM_PIXELS  = ROW_W * NUM_ROWS;
  localparam int NUM_CLASSES = 10;
  localparam int BCD_W       = 4;
  localparam int PIX_IDX_W   = 8;
  localparam int NEURON_W    = 4;
  localparam int CHUNK_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CLR  = 3'd2,
    S_ACC  = 3'd3,
    S_WAIT = 3'd4,
    S_CMP  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/inference_sequencer_argmax_tracker.sv
// Running argmax over neuron scores; strict-greater update so ties keep the lower index.
module argmax_tracker
  import nnacc_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init,
  input  logic                    sample_en,
  input  logic [NEURON_W-1:0]     idx,
  input  logic signed [ACC_W-1:0] val,
  output logic [NEURON_W-1:0]     best_idx,
  output logic signed [ACC_W-1:0] best_val
);
  localparam logic signed [ACC_W-1:0] MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_idx <= '0;
      best_val <= '0;
    end else if (init) begin
      best_idx <= '0;
      best_val <= MOST_NEG;
    end else if (sample_en && (val > best_val)) begin
      best_idx <= idx;
      best_val <= val;
    end
  end
endmodule

// File: rtl/inference_sequencer.sv
// Image loader and MAC sequencer for the 14x14 classifier; emits the winning digit.
// Optional macro SEQ_CYCLE_COUNT_EN enables the per-inference cycle counter.
module inference_sequencer
  import nnacc_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int MAC_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    row_valid,
  input  logic [ROW_W-1:0]        row_data,
  input  logic                    abort,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic [NUM_PIXELS-1:0]   image,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic [PIX_IDX_W-1:0]    mac_pixel_idx,
  output logic [NEURON_W-1:0]     mac_neuron_idx,
  output logic [BCD_W-1:0]        result_digit,
  output logic                    result_valid,
  output logic                    busy,
  output logic [15:0]             cycle_count,
  output state_t                  dbg_state,
  output logic signed [ACC_W-1:0] dbg_best_val
);
  localparam logic [CHUNK_W-1:0]   LAST_CHUNK  = CHUNK_W'(NUM_ROWS - 1);
  localparam logic [PIX_IDX_W-1:0] LAST_PIX    = PIX_IDX_W'(NUM_PIXELS - 1);
  localparam logic [NEURON_W-1:0]  LAST_NEURON = NEURON_W'(NUM_CLASSES - 1);
  localparam logic [7:0]           LAST_WAIT   = 8'(MAC_LAT - 1);

  // Handshake: a chunk transfers on any posedge with row_valid high while the
  // FSM is in IDLE or LOAD; there is no ready, chunks offered elsewhere are dropped.
  state_t               state;
  logic [CHUNK_W-1:0]   chunk_idx;
  logic [7:0]           wait_cnt;
  logic [NEURON_W-1:0]  best_idx;
  logic                 tracker_init;
  logic                 tracker_sample;

  assign tracker_init   = (state == S_LOAD) && row_valid && !abort && (chunk_idx == LAST_CHUNK);
  assign tracker_sample = (state == S_CMP) && !abort;
  assign busy           = (state != S_IDLE);
  assign dbg_state      = state;

  argmax_tracker #(.ACC_W(ACC_W)) u_argmax (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (tracker_init),
    .sample_en (tracker_sample),
    .idx       (mac_neuron_idx),
    .val       (acc_in),
    .best_idx  (best_idx),
    .best_val  (dbg_best_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      chunk_idx      <= '0;
      wait_cnt       <= '0;
      image          <= '0;
      mac_clr        <= 1'b0;
      mac_en         <= 1'b0;
      mac_pixel_idx  <= '0;
      mac_neuron_idx <= '0;
      result_digit   <= '0;
      result_valid   <= 1'b0;
    end else begin
      mac_clr      <= 1'b0;
      mac_en       <= 1'b0;
      result_valid <= 1'b0;
      if (abort) begin
        // Soft restart keeps the image and last result for the display.
        state          <= S_IDLE;
        chunk_idx      <= '0;
        mac_neuron_idx <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (row_valid) begin
              image[ROW_W-1:0] <= row_data;
              chunk_idx        <= CHUNK_W'(1);
              state            <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (row_valid) begin
              for (int c = 1; c < NUM_ROWS; c++) begin
                if (chunk_idx == CHUNK_W'(c)) image[c*ROW_W +: ROW_W] <= row_data;
              end
              if (chunk_idx == LAST_CHUNK) begin
                chunk_idx      <= '0;
                mac_neuron_idx <= '0;
                mac_clr        <= 1'b1;
                state          <= S_CLR;
              end else begin
                chunk_idx <= chunk_idx + CHUNK_W'(1);
              end
            end
          end
          S_CLR: begin
            mac_pixel_idx <= '0;
            mac_en        <= 1'b1;
            state         <= S_ACC;
          end
          S_ACC: begin
            if (mac_pixel_idx == LAST_PIX) begin
              wait_cnt <= '0;
              state    <= S_WAIT;
            end else begin
              mac_en        <= 1'b1;
              mac_pixel_idx <= mac_pixel_idx + PIX_IDX_W'(1);
            end
          end
          S_WAIT: begin
            if (wait_cnt == LAST_WAIT) state <= S_CMP;
            else wait_cnt <= wait_cnt + 8'd1;
          end
          S_CMP: begin
            if (mac_neuron_idx == LAST_NEURON) begin
              state <= S_DONE;
            end else begin
              mac_neuron_idx <= mac_neuron_idx + NEURON_W'(1);
              mac_clr        <= 1'b1;
              state          <= S_CLR;
            end
          end
          S_DONE: begin
            result_digit <= best_idx;
            result_valid <= 1'b1;
            state        <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0] cyc_cnt;

  // The chunk-0 cycle itself counts as 1, so the latched value covers capture through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt     <= '0;
      cycle_count <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (row_valid && !abort) cyc_cnt <= 16'd1;
      end else begin
        cyc_cnt <= sat_inc16(cyc_cnt);
      end
      if ((state == S_DONE) && !abort) cycle_count <= sat_inc16(cyc_cnt);
    end
  end
`else
  assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_inference_sequencer.sv
// Directed-plus-random bench for inference_sequencer with a behavioural MAC datapath stub.
module tb_inference_sequencer;
  import nnacc_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  row_valid = 1'b0;
  logic [ROW_W-1:0]      row_data = '0;
  logic                  abort = 1'b0;
  logic signed [15:0]    acc_in;
  logic [NUM_PIXELS-1:0] image;
  logic                  mac_clr, mac_en, result_valid, busy;
  logic [7:0]            mac_pixel_idx;
  logic [3:0]            mac_neuron_idx, result_digit;
  logic [15:0]           cycle_count;
  state_t                dbg_state;
  logic signed [15:0]    dbg_best_val;

  int n_cmp = 0;
  int n_bad = 0;

  inference_sequencer #(.ACC_W(16), .MAC_LAT(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .row_valid      (row_valid),
    .row_data       (row_data),
    .abort          (abort),
    .acc_in         (acc_in),
    .image          (image),
    .mac_clr        (mac_clr),
    .mac_en         (mac_en),
    .mac_pixel_idx  (mac_pixel_idx),
    .mac_neuron_idx (mac_neuron_idx),
    .result_digit   (result_digit),
    .result_valid   (result_valid),
    .busy           (busy),
    .cycle_count    (cycle_count),
    .dbg_state      (dbg_state),
    .dbg_best_val   (dbg_best_val)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  // MAC datapath stub: weight table, one-cycle accumulate latency, pixel order monitor
  int                 w [NUM_CLASSES][NUM_PIXELS];
  logic signed [15:0] acc = '0;
  int                 pix_exp = 0;
  int                 order_err = 0;
  int                 en_total = 0;
  assign acc_in = acc;

  always @(posedge clk) begin
    if (mac_clr) begin
      acc <= '0;
      pix_exp = 0;
    end else if (mac_en) begin
      if (int'(mac_pixel_idx) != pix_exp) order_err++;
      if (mac_pixel_idx < 8'd196 && mac_neuron_idx < 4'd10)
        acc <= acc + 16'(w[mac_neuron_idx][mac_pixel_idx] * int'(image[mac_pixel_idx]));
      pix_exp++;
      en_total++;
    end
  end

  // Scoreboard comparison
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: score each neuron as a plain dot product, strict-greater argmax
  function automatic logic [3:0] ref_digit(input logic [NUM_PIXELS-1:0] img);
    int best;
    int s;
    logic [3:0] bi;
    best = -32768;
    bi = '0;
    for (int n = 0; n < NUM_CLASSES; n++) begin
      s = 0;
      for (int p = 0; p < NUM_PIXELS; p++) if (img[p]) s += w[n][p];
      if (s > best) begin
        best = s;
        bi = 4'(n);
      end
    end
    return bi;
  endfunction

  task automatic set_targets(input int t [NUM_CLASSES]);
    for (int n = 0; n < NUM_CLASSES; n++)
      for (int p = 0; p < NUM_PIXELS; p++) w[n][p] = (p == 0) ? t[n] : 0;
  endtask

  task automatic set_random_weights();
    for (int n = 0; n < NUM_CLASSES; n++)
      for (int p = 0; p < NUM_PIXELS; p++) w[n][p] = int'($urandom_range(0, 10)) - 5;
  endtask

  function automatic logic [NUM_PIXELS-1:0] rand_image();
    logic [223:0] tmp;
    for (int i = 0; i < 7; i++) tmp[i*32 +: 32] = $urandom;
    return tmp[NUM_PIXELS-1:0];
  endfunction

  // Driver: chunks applied at negedge; span counts edges from chunk 0 to the last chunk
  task automatic send_image(input logic [NUM_PIXELS-1:0] img, input int max_gap, output int span);
    int gap;
    span = 0;
    for (int k = 0; k < NUM_ROWS; k++) begin
      gap = (k == 0 || max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
      for (int g = 0; g < gap; g++) begin
        row_valid = 1'b0;
        @(posedge clk);
        span++;
        @(negedge clk);
      end
      row_valid = 1'b1;
      row_data  = img[k*ROW_W +: ROW_W];
      @(posedge clk);
      if (k > 0) span++;
      @(negedge clk);
    end
    row_valid = 1'b0;
  endtask

  task automatic run_image(input logic [NUM_PIXELS-1:0] img, input int max_gap, input bit toggle,
                           input logic [3:0] exp_digit, input string tag);
    int span;
    int lat;
    bit got;
    int exp_cc;
    order_err = 0;
    en_total  = 0;
    send_image(img, max_gap, span);
    lat = 0;
    got = 1'b0;
    while (lat < 3000 && !got) begin
      if (toggle) begin
        row_valid = 1'($urandom_range(0, 1));
        row_data  = 7'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 500) check({tag, "_busy_compute"}, busy, 1);
      if (result_valid) got = 1'b1;
    end
    row_valid = 1'b0;
`ifdef SEQ_CYCLE_COUNT_EN
    exp_cc = span + 1992;
`else
    exp_cc = 0;
`endif
    check({tag, "_result_seen"}, got, 1);
    check({tag, "_latency"}, lat, 1991);
    check({tag, "_digit"}, result_digit, exp_digit);
    check({tag, "_image"}, image, img);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_cycle_count"}, cycle_count, exp_cc);
    check({tag, "_pixel_order"}, order_err, 0);
    check({tag, "_mac_en_total"}, en_total, NUM_CLASSES * NUM_PIXELS);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_pulse_width"}, result_valid, 0);
    check({tag, "_digit_hold"}, result_digit, exp_digit);
  endtask

  initial begin
    int t [NUM_CLASSES];
    logic [NUM_PIXELS-1:0] ones;
    logic [NUM_PIXELS-1:0] img;
    logic [NUM_PIXELS-1:0] prev_img;
    logic [3:0] prev_digit;
    int pulses;
    int bound;

    ones = '1;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_image", image, 0);
    check("reset_outputs", {mac_clr, mac_en, mac_pixel_idx, mac_neuron_idx, result_digit, result_valid, busy}, 0);
    check("reset_cycle_count", cycle_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state_idle", dbg_state, S_IDLE);

    // Neuron 3 wins with a large positive score
    for (int n = 0; n < NUM_CLASSES; n++) t[n] = 10*n - 40;
    t[3] = 500;
    set_targets(t);
    run_image(ones, 0, 1'b0, 4'd3, "max3");

    // Tie between neurons 2 and 5 keeps the lower index; row_valid toggles during compute
    for (int n = 0; n < NUM_CLASSES; n++) t[n] = 0;
    t[2] = 100;
    t[5] = 100;
    set_targets(t);
    run_image(ones, 0, 1'b1, 4'd2, "tie25");

    // All scores negative
    for (int n = 0; n < NUM_CLASSES; n++) t[n] = -20 - 7*n;
    t[7] = -5;
    set_targets(t);
    run_image(ones, 0, 1'b0, 4'd7, "neg7");

    // Abort after chunk 10 with row_valid in the same cycle
    prev_img   = image;
    prev_digit = result_digit;
    set_random_weights();
    img = rand_image();
    for (int k = 0; k < 10; k++) begin
      row_valid = 1'b1;
      row_data  = img[k*ROW_W +: ROW_W];
      @(posedge clk);
      @(negedge clk);
    end
    row_valid = 1'b1;
    row_data  = img[10*ROW_W +: ROW_W];
    abort     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    row_valid = 1'b0;
    abort     = 1'b0;
    check("abort_state_idle", dbg_state, S_IDLE);
    check("abort_busy", busy, 0);
    check("abort_image_kept", image, {prev_img[NUM_PIXELS-1:70], img[69:0]});
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (result_valid) pulses++;
    end
    check("abort_no_result", pulses, 0);
    check("abort_digit_kept", result_digit, prev_digit);
    run_image(img, 2, 1'b0, ref_digit(img), "post_abort");

    // Asynchronous reset mid-ACC at pixel 100
    set_random_weights();
    img = rand_image();
    begin
      int span;
      send_image(img, 0, span);
    end
    bound = 0;
    while (bound < 400 && !(mac_en && mac_pixel_idx == 8'd100)) begin
      @(posedge clk);
      @(negedge clk);
      bound++;
    end
    check("rst_reach_pixel100", bound < 400, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_image", image, 0);
    check("rst_async_outputs", {mac_clr, mac_en, mac_pixel_idx, mac_neuron_idx, result_digit, result_valid, busy}, 0);
    check("rst_async_cycle_count", cycle_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_image(img, 0, 1'b0, ref_digit(img), "post_reset");

    // Randomized images, weights and inter-chunk gaps
    for (int r = 0; r < 4; r++) begin
      set_random_weights();
      img = rand_image();
      run_image(img, 3, 1'(r & 1), ref_digit(img), $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
